// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
//   Constants shared between the control unit and the fetch unit: the
//   opcodes that affect the return-address stack, the next-PC select
//   encodings and the fetch state type.
package pc_fetch_unit_pkg;

  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RETURN = 2'b11
  } pcsrc_e;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_ras.sv
// return_address_stack
//   Circular return-address stack. A push while full overwrites the oldest
//   entry; a pop while empty changes nothing but the underflow flag.
//   Ports:
//     clock, reset        clock, async active-high reset
//     push, pop           stack operations (never both at once)
//     pushData            return address to push
//     top                 most recently pushed entry
//     count               number of valid entries (0..RAS_DEPTH)
//     full, empty         count == RAS_DEPTH / count == 0
//     overflow, underflow sticky error flags, cleared only by reset
module return_address_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [ADDR_W-1:0]                pushData,
  output logic [ADDR_W-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              underflow_q;

  assign full      = (count_q == CNT_W'(RAS_DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  // wptr points at the next free slot, so the top sits one below it
  assign top       = stack_q[wptr_q - PTR_W'(1)];

  always_ff @(posedge clock) begin
    if (push) stack_q[wptr_q] <= pushData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push) begin
      // pointer wraps naturally (power-of-2 depth); a full push drops the oldest
      wptr_q <= wptr_q + PTR_W'(1);
      if (full) overflow_q <= 1'b1;
      else      count_q    <= count_q + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        underflow_q <= 1'b1;
      end else begin
        wptr_q  <= wptr_q - PTR_W'(1);
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns PC, IR and the return-address stack; advances one instruction per
//   enIF strobe from the control unit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FIRST | after reset; next fetch is RESET_VECTOR, sigPCSrc ignored
//   ST_RUN   | normal operation; next fetch address chosen by sigPCSrc
//
//   Ports:
//     clock, reset     clock, async active-high reset
//     enIF             fetch strobe (fetches on every high cycle)
//     sigPCSrc         next-PC select for the instruction in IR
//     instrMemData     instruction memory data at fetchAddress
//     fetchAddress     combinational next PC / memory address
//     pc, ir           address and contents of the current instruction
//     instructionCode  ir[15:12]
//     rasEmpty/Full    stack occupancy
//     rasOverflow/Underflow  sticky stack error flags
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                INSTR_W      = 16,
  parameter int                RAS_DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enIF,
  input  logic [1:0]         sigPCSrc,
  input  logic [INSTR_W-1:0] instrMemData,
  output logic [ADDR_W-1:0]  fetchAddress,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         instructionCode,
  output logic               rasEmpty,
  output logic               rasFull,
  output logic               rasOverflow,
  output logic               rasUnderflow
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] ir_q;

  logic                           ras_push;
  logic                           ras_pop;
  logic [ADDR_W-1:0]              ras_top;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;
  logic [ADDR_W-1:0]              pc_plus1;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  always_comb begin
    next_pc = pc_plus1;
    unique case (pcsrc_e'(sigPCSrc))
      PC_INC:    next_pc = pc_plus1;
      PC_BRANCH: next_pc = pc_q + {{(ADDR_W-6){ir_q[5]}}, ir_q[5:0]};
      PC_JUMP:   next_pc = {pc_q[ADDR_W-1:12], ir_q[11:0]};
      PC_RETURN: next_pc = (ras_count != '0) ? ras_top : RESET_VECTOR;
      default:   next_pc = pc_plus1;
    endcase
  end

  assign pc_d         = (state_q == ST_FIRST) ? RESET_VECTOR : next_pc;
  assign fetchAddress = pc_d;

  assign ras_push = enIF && (state_q == ST_RUN) && (pcsrc_e'(sigPCSrc) == PC_JUMP)
                    && (ir_q[15:12] == OP_CALL);
  assign ras_pop  = enIF && (state_q == ST_RUN) && (pcsrc_e'(sigPCSrc) == PC_RETURN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FIRST;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
    end else if (enIF) begin
      pc_q <= pc_d;
      ir_q <= instrMemData;
      case (state_q)
        ST_FIRST: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  return_address_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .pushData  (pc_plus1),
    .top       (ras_top),
    .count     (ras_count),
    .full      (rasFull),
    .empty     (rasEmpty),
    .overflow  (rasOverflow),
    .underflow (rasUnderflow)
  );

  assign pc              = pc_q;
  assign ir              = ir_q;
  assign instructionCode = ir_q[15:12];

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        enIF;
  logic [1:0]  sigPCSrc;
  logic [15:0] instrMemData;
  logic [15:0] fetchAddress;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [3:0]  instructionCode;
  logic        rasEmpty, rasFull, rasOverflow, rasUnderflow;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  bit          m_first;
  logic [15:0] m_ras[$];
  bit          m_ovf;
  bit          m_unf;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
  } exp_t;
  exp_t sb[$];

  pc_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enIF            (enIF),
    .sigPCSrc        (sigPCSrc),
    .instrMemData    (instrMemData),
    .fetchAddress    (fetchAddress),
    .pc              (pc),
    .ir              (ir),
    .instructionCode (instructionCode),
    .rasEmpty        (rasEmpty),
    .rasFull         (rasFull),
    .rasOverflow     (rasOverflow),
    .rasUnderflow    (rasUnderflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".rasEmpty"},     {31'd0, rasEmpty},     {31'd0, m_ras.size() == 0});
    chk({tag, ".rasFull"},      {31'd0, rasFull},      {31'd0, m_ras.size() == 8});
    chk({tag, ".rasOverflow"},  {31'd0, rasOverflow},  {31'd0, m_ovf});
    chk({tag, ".rasUnderflow"}, {31'd0, rasUnderflow}, {31'd0, m_unf});
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_ir = 16'h0; m_first = 1'b1;
    m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    sb.delete();
  endtask

  // Drives one fetch (enIF stays high until idle() drops it) and checks the
  // resulting pc/ir against the scoreboard entry queued at drive time.
  task automatic step(input string tag, input logic [1:0] src, input logic [15:0] data);
    logic [15:0] npc;
    exp_t e;
    sigPCSrc = src; instrMemData = data; enIF = 1'b1;
    npc = 16'h0;
    if (!m_first) begin
      case (src)
        2'b00: npc = m_pc + 16'd1;
        2'b01: npc = m_pc + {{10{m_ir[5]}}, m_ir[5:0]};
        2'b10: begin
          npc = {m_pc[15:12], m_ir[11:0]};
          if (m_ir[15:12] == 4'hD) begin
            if (m_ras.size() == 8) begin
              void'(m_ras.pop_front());
              m_ovf = 1'b1;
            end
            m_ras.push_back(m_pc + 16'd1);
          end
        end
        default: begin
          if (m_ras.size() == 0) begin
            npc = 16'h0;
            m_unf = 1'b1;
          end else begin
            npc = m_ras.pop_back();
          end
        end
      endcase
    end
    #1;
    chk({tag, ".fetchAddress"}, {16'd0, fetchAddress}, {16'd0, npc});
    e.pc = npc; e.ir = data;
    sb.push_back(e);
    m_pc = npc; m_ir = data; m_first = 1'b0;
    @(posedge clock); #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, {16'd0, pc}, {16'd0, e.pc});
    chk({tag, ".ir"}, {16'd0, ir}, {16'd0, e.ir});
    chk({tag, ".code"}, {28'd0, instructionCode}, {28'd0, e.ir[15:12]});
    chk_flags(tag);
  endtask

  task automatic idle(input int n);
    enIF = 1'b0;
    for (int i = 0; i < n; i++) begin
      sigPCSrc = 2'($urandom_range(3, 0));
      instrMemData = 16'($urandom);
      @(posedge clock); #1;
      chk("idle.pc", {16'd0, pc}, {16'd0, m_pc});
      chk("idle.ir", {16'd0, ir}, {16'd0, m_ir});
      chk_flags("idle");
    end
  endtask

  initial begin
    reset = 1'b1; enIF = 1'b0; sigPCSrc = 2'b00; instrMemData = 16'h0;
    model_reset();
    #11;
    chk("rst.pc", {16'd0, pc}, 32'h0);
    chk("rst.ir", {16'd0, ir}, 32'h0);
    chk("rst.fetchAddress", {16'd0, fetchAddress}, 32'h0);
    chk_flags("rst");
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // first fetch ignores sigPCSrc
    step("first", 2'b11, 16'h1123);
    step("inc1", 2'b00, 16'h0000);
    step("inc2", 2'b00, 16'h0000);
    step("inc3", 2'b00, 16'h0000);
    step("inc4", 2'b00, 16'hD020);
    // CALL 0x020 from pc=4, then return to 5 carrying a negative branch
    step("call", 2'b10, 16'h0000);
    step("ret", 2'b11, 16'h903E);
    step("br_neg", 2'b01, 16'h0000);
    step("inc5", 2'b00, 16'h0000);
    step("inc6", 2'b00, 16'h9005);
    step("br_pos", 2'b01, 16'hC030);
    step("jmp", 2'b10, 16'h0000);

    // 9 consecutive CALLs: fills at 8, overflows at 9
    step("pre_call", 2'b00, 16'hD100);
    for (int i = 1; i <= 9; i++) begin
      step("calln", 2'b10, 16'hD100 + 16'(i));
      if (i == 8) chk("full_after_8", {31'd0, rasFull}, 32'd1);
    end
    chk("ovf_after_9", {31'd0, rasOverflow}, 32'd1);
    for (int i = 0; i < 8; i++) step("retn", 2'b11, 16'h0000);
    step("ret_empty", 2'b11, 16'h0000);
    chk("unf_pc", {16'd0, pc}, 32'h0);

    idle(5);

    // some CALLs then reset in the middle of a cycle
    step("c_a", 2'b00, 16'hD200);
    step("c_b", 2'b10, 16'hD201);
    step("c_c", 2'b10, 16'hD202);
    enIF = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst.pc", {16'd0, pc}, 32'h0);
    chk("mid_rst.ir", {16'd0, ir}, 32'h0);
    chk("mid_rst.fetchAddress", {16'd0, fetchAddress}, 32'h0);
    chk_flags("mid_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    step("after_rst", 2'b11, 16'h2222);
    step("after_rst_inc", 2'b00, 16'h3333);
    enIF = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
